// File: rtl/l1_icache_pkg.sv
// Package lc3b_types: the word, line and state types used by the L1 instruction
// cache. The L2 uses the same line width.
//   lc3b_word          16-bit machine word / byte address
//   lc3b_line          128-bit cache line (LINE_WORDS words)
//   lc3b_icache_state  L1 I-cache controller states
package lc3b_types;

  localparam int WORD_BITS   = 16;
  localparam int LINE_WORDS  = 8;
  localparam int LINE_BITS   = WORD_BITS * LINE_WORDS;  // shared with L2
  localparam int OFFSET_BITS = 4;                       // byte offset within a line

  typedef logic [WORD_BITS-1:0] lc3b_word;
  typedef logic [LINE_BITS-1:0] lc3b_line;

  typedef enum logic {
    IC_IDLE = 1'b0,
    IC_FILL = 1'b1
  } lc3b_icache_state;

endpackage

// File: rtl/l1_icache_array.sv
// Storage for the direct-mapped L1 I-cache: valid bits, tags and line data.
// Reads are asynchronous, writes happen on the rising clock edge.
// Ports:
//   clk, reset    clock; asynchronous active-high reset (clears valid bits only)
//   i_rd_index    lookup index
//   o_rd_valid    valid bit, tag and line at i_rd_index
//   o_rd_tag
//   o_rd_line
//   i_wr_en       line fill: write i_wr_tag/i_wr_line at i_wr_index and set valid
//   i_wr_index
//   i_wr_tag
//   i_wr_line
//   i_clear       clear every valid bit; wins over a coincident fill
module l1_icache_array
  import lc3b_types::*;
#(
  parameter int NUM_SETS = 8,
  parameter int IDX_W    = $clog2(NUM_SETS),
  parameter int TAG_W    = WORD_BITS - OFFSET_BITS - IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] i_rd_index,
  output logic             o_rd_valid,
  output logic [TAG_W-1:0] o_rd_tag,
  output lc3b_line         o_rd_line,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_index,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  lc3b_line         i_wr_line,
  input  logic             i_clear
);

  logic [NUM_SETS-1:0] r_valid;
  logic [TAG_W-1:0]    r_tag  [NUM_SETS];
  lc3b_line            r_data [NUM_SETS];

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge value of its inputs, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
    end else if (i_clear) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays carry no reset; the valid bits alone decide
  // whether their contents mean anything, so they can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_data[i_wr_index] <= i_wr_line;
    end
  end

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_line  = r_data[i_rd_index];

endmodule

// File: rtl/l1_icache.sv
// Direct-mapped, read-only L1 instruction cache. It answers fetch reads
// combinationally on a hit. On a miss it fills one whole line from lower memory,
// then the request hits on the cycle after the fill returns.
// Ports:
//   clk, reset    clock; asynchronous active-high reset
//   mem_read1     fetch read request (level, held until resp_a)
//   mem_address   fetch byte address (bit 0 ignored)
//   mem_rdata     instruction word, zero unless resp_a
//   resp_a        one-cycle read acknowledge
//   invalidate    clear all valid bits at the next edge; suppresses resp_a
//   pmem_read     line-fill request (level, held until pmem_resp)
//   pmem_address  line-aligned fill address
//   pmem_rdata    fill line, sampled when pmem_resp is high
//   pmem_resp     lower-memory completion strobe
module l1_icache
  import lc3b_types::*;
#(
  parameter int NUM_SETS = 8
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     mem_read1,
  input  lc3b_word mem_address,
  output lc3b_word mem_rdata,
  output logic     resp_a,
  input  logic     invalidate,
  output logic     pmem_read,
  output lc3b_word pmem_address,
  input  lc3b_line pmem_rdata,
  input  logic     pmem_resp
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = WORD_BITS - OFFSET_BITS - IDX_W;

  lc3b_icache_state r_state, w_next_state;
  logic [WORD_BITS-1:OFFSET_BITS] r_fill_line;  // line address of the fill in progress

  logic [IDX_W-1:0] w_index;
  logic [TAG_W-1:0] w_tag;
  logic [2:0]       w_word;
  logic             w_unused_byte;
  logic             w_valid;
  logic [TAG_W-1:0] w_stored_tag;
  lc3b_line         w_line;
  logic             w_hit;
  logic             w_miss;
  logic             w_fill_we;

  assign w_index       = mem_address[OFFSET_BITS +: IDX_W];
  assign w_tag         = mem_address[WORD_BITS-1 -: TAG_W];
  assign w_word        = mem_address[3:1];
  assign w_unused_byte = mem_address[0];

  l1_icache_array #(
    .NUM_SETS (NUM_SETS),
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W)
  ) u_array (
    .clk        (clk),
    .reset      (reset),
    .i_rd_index (w_index),
    .o_rd_valid (w_valid),
    .o_rd_tag   (w_stored_tag),
    .o_rd_line  (w_line),
    .i_wr_en    (w_fill_we),
    .i_wr_index (r_fill_line[OFFSET_BITS +: IDX_W]),
    .i_wr_tag   (r_fill_line[WORD_BITS-1 -: TAG_W]),
    .i_wr_line  (pmem_rdata),
    .i_clear    (invalidate)
  );

  // Lookups only count in IDLE; a pending invalidate makes the line untrustworthy.
  assign w_hit = (r_state == IC_IDLE) && mem_read1 && w_valid &&
                 (w_stored_tag == w_tag) && !invalidate;

  assign resp_a       = w_hit;
  assign mem_rdata    = w_hit ? w_line[{w_word, 4'b0000} +: WORD_BITS] : '0;
  assign pmem_address = {r_fill_line, {OFFSET_BITS{1'b0}}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IC_IDLE;
      r_fill_line <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_miss) begin
        r_fill_line <= mem_address[WORD_BITS-1:OFFSET_BITS];
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    pmem_read    = 1'b0;
    w_fill_we    = 1'b0;
    w_miss       = 1'b0;
    case (r_state)
      IC_IDLE: begin
        if (mem_read1 && !w_hit && !invalidate) begin
          w_miss       = 1'b1;
          w_next_state = IC_FILL;
        end
      end
      IC_FILL: begin
        // The fill always runs to completion for the latched line, whatever fetch does.
        pmem_read = 1'b1;
        if (pmem_resp) begin
          w_fill_we    = 1'b1;
          w_next_state = IC_IDLE;
        end
      end
      default: w_next_state = IC_IDLE;
    endcase
  end

endmodule
